// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared constants and types for the remote-blink design
package blink_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] CMD_ON   = 8'h01;
    localparam logic [7:0] CMD_OFF  = 8'h02;
    localparam logic [7:0] CMD_MASK = 8'h03;

    localparam logic [7:0] DEFAULT_LED_MASK = 8'h55;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_D3,
        P_D2,
        P_D1,
        P_D0,
        P_CHK
    } parse_state_t;

    // Defaults give a 75% / 25% duty one-second blink; the generator uses the same functions.
    function automatic logic [31:0] default_on_ticks(input int clk_freq);
        longint v;
        v = (longint'(clk_freq) * 3) / 4;
        return v[31:0];
    endfunction

    function automatic logic [31:0] default_off_ticks(input int clk_freq);
        longint v;
        v = longint'(clk_freq) / 4;
        return v[31:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
module uart_rx_byte
    import blink_pkg::*;
#(
    parameter int BIT_TICKS = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(BIT_TICKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_TICKS / 2 - 1);

    logic       sync1;
    logic       sync2;
    logic       rx_prev;
    logic [1:0] fill;
    logic       fall;

    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
        end
    end

    // rx_prev only starts tracking once the synchronizer holds real line samples,
    // so a line already low at reset release needs a high phase before it can fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill    <= 2'd0;
            rx_prev <= 1'b0;
        end else if (fill != 2'd2) begin
            fill <= fill + 2'd1;
        end else begin
            rx_prev <= sync2;
        end
    end

    assign fall      = rx_prev & ~sync2;
    assign byte_data = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (fall) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (sync2) byte_valid <= 1'b1;
                        else       frame_err  <= 1'b1;
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/blink_cmd_rx.sv
// rtl/blink_cmd_rx.sv - UART command parser holding the blink configuration registers
module blink_cmd_rx
    import blink_pkg::*;
#(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int BAUD          = 115200,
    parameter int TIMEOUT_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [31:0] on_ticks,
    output logic [31:0] off_ticks,
    output logic [7:0]  led_mask,
    output logic        cfg_valid,
    output logic        cmd_err,
    output logic        frame_err
);

    localparam int          BIT_TICKS   = CLK_FREQ / BAUD;
    localparam int          TIMEOUT_CYC = TIMEOUT_BYTES * 10 * BIT_TICKS;
    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] ON_RST      = default_on_ticks(CLK_FREQ);
    localparam logic [31:0] OFF_RST     = default_off_ticks(CLK_FREQ);

    logic [7:0] byte_data;
    logic       byte_valid;

    parse_state_t state;
    logic [7:0]   cmd;
    logic [31:0]  payload;
    logic [7:0]   chk;
    logic [31:0]  to_cnt;

    uart_rx_byte #(
        .BIT_TICKS (BIT_TICKS)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= P_HDR;
            cmd       <= '0;
            payload   <= '0;
            chk       <= '0;
            to_cnt    <= '0;
            on_ticks  <= ON_RST;
            off_ticks <= OFF_RST;
            led_mask  <= DEFAULT_LED_MASK;
            cfg_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (frame_err) begin
                state  <= P_HDR;
                to_cnt <= '0;
            end else if (byte_valid) begin
                // to_cnt counts cycles since the strobe, so the strobe cycle itself is 0
                to_cnt <= 32'd1;
                case (state)
                    P_HDR: begin
                        if (byte_data == HDR_BYTE) state <= P_CMD;
                    end
                    P_CMD: begin
                        cmd   <= byte_data;
                        chk   <= byte_data;
                        state <= P_D3;
                    end
                    P_D3, P_D2, P_D1, P_D0: begin
                        payload <= {payload[23:0], byte_data};
                        chk     <= chk ^ byte_data;
                        state   <= parse_state_t'(state + 3'd1);
                    end
                    P_CHK: begin
                        state <= P_HDR;
                        if (byte_data != chk) begin
                            cmd_err <= 1'b1;
                        end else begin
                            case (cmd)
                                CMD_ON: begin
                                    if (payload == '0) cmd_err <= 1'b1;
                                    else begin
                                        on_ticks  <= payload;
                                        cfg_valid <= 1'b1;
                                    end
                                end
                                CMD_OFF: begin
                                    if (payload == '0) cmd_err <= 1'b1;
                                    else begin
                                        off_ticks <= payload;
                                        cfg_valid <= 1'b1;
                                    end
                                end
                                CMD_MASK: begin
                                    led_mask  <= payload[7:0];
                                    cfg_valid <= 1'b1;
                                end
                                default: cmd_err <= 1'b1;
                            endcase
                        end
                    end
                    default: state <= P_HDR;
                endcase
            end else if (state != P_HDR) begin
                if (to_cnt == TO_LAST) begin
                    cmd_err <= 1'b1;
                    state   <= P_HDR;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_blink_cmd_rx.sv
// tb/tb_blink_cmd_rx.sv - directed self-checking bench for blink_cmd_rx
module tb_blink_cmd_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] on_ticks;
    logic [31:0] off_ticks;
    logic [7:0]  led_mask;
    logic        cfg_valid;
    logic        cmd_err;
    logic        frame_err;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int cfg_n = 0, err_n = 0, ferr_n = 0;
    int cfg_cyc = -1, err_cyc = -1, ferr_cyc = -1;

    blink_cmd_rx #(
        .CLK_FREQ      (1_000_000),
        .BAUD          (100_000),
        .TIMEOUT_BYTES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .on_ticks  (on_ticks),
        .off_ticks (off_ticks),
        .led_mask  (led_mask),
        .cfg_valid (cfg_valid),
        .cmd_err   (cmd_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge: counts high samples and remembers when they occurred.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cfg_valid) begin cfg_n  <= cfg_n + 1;  cfg_cyc  <= cyc; end
        if (cmd_err)   begin err_n  <= err_n + 1;  err_cyc  <= cyc; end
        if (frame_err) begin ferr_n <= ferr_n + 1; ferr_cyc <= cyc; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
        @(negedge clk);
        start_cyc = cyc;
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [55:0] f, output int last_start);
        int s;
        for (int i = 6; i >= 0; i--) begin
            send_byte(f[i*8 +: 8], 1'b1, s);
        end
        last_start = s;
    endtask

    task automatic check_cfg(input logic [31:0] on_e, input logic [31:0] off_e, input logic [7:0] mask_e);
        tests++;
        if (on_ticks !== on_e) begin
            fails++; $display("FAIL on_ticks: got %0d want %0d", on_ticks, on_e);
        end
        tests++;
        if (off_ticks !== off_e) begin
            fails++; $display("FAIL off_ticks: got %0d want %0d", off_ticks, off_e);
        end
        tests++;
        if (led_mask !== mask_e) begin
            fails++; $display("FAIL led_mask: got %h want %h", led_mask, mask_e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_cfg(32'd750000, 32'd250000, 8'h55);
        tests++;
        if ({cfg_valid, cmd_err, frame_err} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses: got %b want 000", {cfg_valid, cmd_err, frame_err});
        end
        tests++;
        if (cfg_n + err_n + ferr_n !== 0) begin
            fails++; $display("FAIL reset_pulse_count: got %0d want 0", cfg_n + err_n + ferr_n);
        end
    endtask

    task automatic test_set_on();
        int c, n0, e0;
        n0 = cfg_n; e0 = err_n;
        send_frame(56'hA5_01_00_00_00_64_65, c);
        repeat (5) @(negedge clk);
        check_cfg(32'd100, 32'd250000, 8'h55);
        tests++;
        if (cfg_n - n0 !== 1) begin
            fails++; $display("FAIL set_on_cfg_count: got %0d want 1", cfg_n - n0);
        end
        tests++;
        if (cfg_cyc - c !== 99) begin
            fails++; $display("FAIL set_on_cfg_time: got %0d want 99", cfg_cyc - c);
        end
        tests++;
        if (err_n - e0 !== 0) begin
            fails++; $display("FAIL set_on_no_err: got %0d want 0", err_n - e0);
        end
    endtask

    task automatic test_mask_noise();
        int c, n0, e0;
        n0 = cfg_n; e0 = err_n;
        send_byte(8'h3C, 1'b1, c);
        send_frame(56'hA5_03_00_00_00_0F_0C, c);
        repeat (5) @(negedge clk);
        check_cfg(32'd100, 32'd250000, 8'h0F);
        tests++;
        if (cfg_n - n0 !== 1) begin
            fails++; $display("FAIL mask_cfg_count: got %0d want 1", cfg_n - n0);
        end
        tests++;
        if (err_n - e0 !== 0) begin
            fails++; $display("FAIL mask_noise_err: got %0d want 0", err_n - e0);
        end
    endtask

    task automatic test_rejects();
        int c, n0, e0;
        n0 = cfg_n;
        e0 = err_n;
        send_frame(56'hA5_01_00_00_00_64_66, c);
        repeat (5) @(negedge clk);
        tests++;
        if (err_n - e0 !== 1) begin
            fails++; $display("FAIL bad_chk_err_count: got %0d want 1", err_n - e0);
        end
        tests++;
        if (err_cyc - c !== 99) begin
            fails++; $display("FAIL bad_chk_err_time: got %0d want 99", err_cyc - c);
        end
        e0 = err_n;
        send_frame(56'hA5_02_00_00_00_00_02, c);
        repeat (5) @(negedge clk);
        tests++;
        if (err_n - e0 !== 1) begin
            fails++; $display("FAIL zero_payload_err: got %0d want 1", err_n - e0);
        end
        e0 = err_n;
        send_frame(56'hA5_07_00_00_00_01_06, c);
        repeat (5) @(negedge clk);
        tests++;
        if (err_n - e0 !== 1) begin
            fails++; $display("FAIL unknown_cmd_err: got %0d want 1", err_n - e0);
        end
        tests++;
        if (cfg_n - n0 !== 0) begin
            fails++; $display("FAIL rejects_cfg_count: got %0d want 0", cfg_n - n0);
        end
        check_cfg(32'd100, 32'd250000, 8'h0F);
    endtask

    task automatic test_frame_err();
        int c, n0, e0, f0;
        n0 = cfg_n; e0 = err_n; f0 = ferr_n;
        send_byte(8'hA5, 1'b1, c);
        send_byte(8'h01, 1'b0, c);
        repeat (5) @(negedge clk);
        tests++;
        if (ferr_n - f0 !== 1) begin
            fails++; $display("FAIL frame_err_count: got %0d want 1", ferr_n - f0);
        end
        tests++;
        if (ferr_cyc - c !== 98) begin
            fails++; $display("FAIL frame_err_time: got %0d want 98", ferr_cyc - c);
        end
        send_frame(56'hA5_02_00_00_01_00_03, c);
        repeat (5) @(negedge clk);
        check_cfg(32'd100, 32'd256, 8'h0F);
        tests++;
        if (cfg_n - n0 !== 1 || err_n - e0 !== 0) begin
            fails++; $display("FAIL after_frame_err: got cfg %0d err %0d want cfg 1 err 0", cfg_n - n0, err_n - e0);
        end
    endtask

    task automatic test_timeout();
        int c, e0;
        e0 = err_n;
        send_byte(8'hA5, 1'b1, c);
        send_byte(8'h02, 1'b1, c);
        repeat (300) @(negedge clk);
        tests++;
        if (err_n - e0 !== 1) begin
            fails++; $display("FAIL timeout_err_count: got %0d want 1", err_n - e0);
        end
        tests++;
        if (err_cyc - c !== 298) begin
            fails++; $display("FAIL timeout_err_time: got %0d want 298", err_cyc - c);
        end
        check_cfg(32'd100, 32'd256, 8'h0F);
    endtask

    task automatic test_reset_mid_frame();
        int c, n0, e0, f0;
        send_byte(8'hA5, 1'b1, c);
        send_byte(8'h01, 1'b1, c);
        send_byte(8'h00, 1'b1, c);
        send_byte(8'h00, 1'b1, c);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cfg(32'd750000, 32'd250000, 8'h55);
        repeat (5) @(negedge clk);
        n0 = cfg_n; e0 = err_n; f0 = ferr_n;
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (ferr_n - f0 !== 0 || err_n - e0 !== 0) begin
            fails++; $display("FAIL low_at_release: got ferr %0d err %0d want 0 0", ferr_n - f0, err_n - e0);
        end
        send_frame(56'hA5_01_00_00_01_F4_F4, c);
        repeat (5) @(negedge clk);
        check_cfg(32'd500, 32'd250000, 8'h55);
        tests++;
        if (cfg_n - n0 !== 1) begin
            fails++; $display("FAIL post_reset_cfg_count: got %0d want 1", cfg_n - n0);
        end
    endtask

    initial begin
        test_reset();
        test_set_on();
        test_mask_noise();
        test_rejects();
        test_frame_err();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_cmd_rx.md
# blink_cmd_rx

Serial command front-end for the remote-blink design. Receives 8N1 UART bytes on `uart_rx` and parses fixed 7-byte command frames. It holds the blink configuration registers (ON duration, OFF duration, LED mask) that directly feed the blink generator stage downstream. Invalid frames are dropped and leave the configuration untouched.

## Interface
- `CLK_FREQ`, 25_000_000, clock frequency in Hz.
- `BAUD`, 115200, UART bit rate; `BIT_TICKS = CLK_FREQ / BAUD` (integer division, must be ≥ 4).
- `TIMEOUT_BYTES`, 2, inter-byte idle limit in byte-times (10·BIT_TICKS each).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `on_ticks`  out  32  ON duration in clk cycles; reset `(CLK_FREQ*3)/4`.
- `off_ticks`  out  32  OFF duration in clk cycles; reset `CLK_FREQ/4`.
- `led_mask`  out  8  LEDs driven by the blinker; reset 8'h55.
- `cfg_valid`  out  1  one-cycle pulse when any config register updates; reset 0.
- `cmd_err`  out  1  one-cycle pulse on a rejected frame or timeout; reset 0.
- `frame_err`  out  1  one-cycle pulse on a UART stop-bit error; reset 0.

## Operation
- **Input path.** `uart_rx` passes through a 2-FF synchronizer. Both FFs reset to 1.
- **RX FSM states: IDLE, START, DATA, STOP.**
  - IDLE → START on a synchronized falling edge.
  - START: sample at BIT_TICKS/2. If the line is high, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits LSB-first, each one BIT_TICKS after the previous sample.
  - STOP: sample one more BIT_TICKS later. If high, emit the byte. If low, pulse `frame_err`, discard the byte and reset the parser to HDR. Return to IDLE in either case.
- **Frame format:** `0xA5, CMD, D3, D2, D1, D0, CHK`.
  - Payload `D3..D0` is big-endian 32-bit.
  - `CHK = CMD ^ D3 ^ D2 ^ D1 ^ D0`.
- **Parser states: HDR, CMD, D3, D2, D1, D0, CHK.**
  - In HDR, any byte other than 0xA5 is ignored silently.
  - In the other states, 0xA5 is treated as ordinary data. There is no resync.
- **Commands:**
  - 0x01 → `on_ticks <= payload`.
  - 0x02 → `off_ticks <= payload`.
  - 0x03 → `led_mask <= D0`. D3..D1 are ignored but still included in CHK.
- **Reject conditions** (each gives a `cmd_err` pulse, no register change, parser returns to HDR):
  - bad CHK;
  - unknown CMD;
  - payload 0 for CMD 0x01 or 0x02.
- **Timeout.** If the parser is not in HDR and no byte arrives within `TIMEOUT_BYTES·10·BIT_TICKS` cycles of the last byte, pulse `cmd_err` and return to HDR.
- **Register stability.** Outputs change only on an accepted frame. They never hold a partially written value.

## Timing
- **Byte emit.** Internal byte strobe occurs 1 cycle after the stop-bit sample cycle.
- **Commit.** A config register and `cfg_valid` both update on the clk edge after the CHK byte strobe, i.e. the new value is visible in the same cycle `cfg_valid` is high.
- **Same-cycle events.** If a byte strobe and the timeout expiry fall in the same cycle, the byte wins and the timeout does not fire.
- **Pulse widths.** `cmd_err`, `frame_err` and `cfg_valid` are each exactly 1 cycle and are mutually exclusive per frame.
- **Mid-frame reset.** Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronously). After release, the RX FSM waits in IDLE for a fresh falling edge. A low line at release is not a start bit until it is seen high and then falling.

## Structure
- **Shared package `blink_pkg`** holds:
  - `HDR_BYTE` = 8'hA5;
  - CMD codes `CMD_ON`, `CMD_OFF`, `CMD_MASK`;
  - the default ON/OFF/mask expressions, shared with the blink generator so the reset behaviour matches.
- **Sub-module `uart_rx_byte`** (synchronizer + RX FSM) outputs `byte_data[7:0]`, `byte_valid` and `frame_err`.
- **Top level** contains the parser FSM, the timeout counter and the config registers.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000`, so BIT_TICKS=10.

- **Reset:** after release, `on_ticks`=750000, `off_ticks`=250000, `led_mask`=8'h55, and all pulses are 0.
- **Set ON:** send A5 01 00 00 00 64 65 → `on_ticks`=100 and `cfg_valid` high for 1 cycle, 1 cycle after the stop-bit sample of 0x65.
- **Set mask with a noise byte:** send 3C A5 03 00 00 00 0F 0C → `led_mask`=8'h0F. The leading 0x3C is ignored with no `cmd_err`.
- **Rejects:**
  - A5 01 00 00 00 64 66 (bad CHK) → `cmd_err` pulse, `on_ticks` unchanged.
  - A5 02 00 00 00 00 02 (zero payload) → `cmd_err` pulse, `off_ticks` unchanged.
  - A5 07 … (unknown CMD, valid CHK) → `cmd_err` pulse.
- **Framing and timeout:**
  - Send A5 01 with the stop bit of the second byte driven low → `frame_err` pulse. A following valid frame is accepted.
  - Send A5 02 then stay idle for 200 cycles → `cmd_err` pulse at cycle 200 after the last byte strobe.
- **Reset mid-frame:** assert `rst_n` low during D1 of a CMD 0x01 frame → outputs return to defaults, and a full valid frame sent after release is accepted.
